// File: rtl/ddr_dq_responder_if.sv
// CAS command / DQ bus bundle between a DDR controller (master) and the DRAM-side
// responder (slave). dm_n exists only when DDR_RESP_DM_EN is defined.
interface ddr_dq_responder_if #(
  parameter int unsigned DQ_WIDTH = 8,
  parameter int unsigned ADDR_W   = 10
);
  logic                cas_valid;
  logic                cas_is_wr;
  logic [ADDR_W-1:0]   cas_col;
  logic [4:0]          CL;
  logic [4:0]          CWL;
  logic [4:0]          AL;
  logic [1:0]          RD_PRE;
  logic [1:0]          WR_PRE;
  logic [DQ_WIDTH-1:0] dq_in;
`ifdef DDR_RESP_DM_EN
  logic                dm_n;
`endif
  logic [DQ_WIDTH-1:0] dq_out;
  logic                dq_oe;
  logic                dqs_t;
  logic                dqs_c;
  logic                dqs_oe;
  logic                wr_beat;
  logic                busy;
  logic                overflow;
  logic                late_err;

  modport master (
`ifdef DDR_RESP_DM_EN
    output dm_n,
`endif
    output cas_valid, cas_is_wr, cas_col, CL, CWL, AL, RD_PRE, WR_PRE, dq_in,
    input  dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, wr_beat, busy, overflow, late_err
  );

  modport slave (
`ifdef DDR_RESP_DM_EN
    input  dm_n,
`endif
    input  cas_valid, cas_is_wr, cas_col, CL, CWL, AL, RD_PRE, WR_PRE, dq_in,
    output dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, wr_beat, busy, overflow, late_err
  );
endinterface

// File: rtl/ddr_dq_responder.sv
// DRAM-side CAS responder: queues RD/WR commands with their issue time and, at the
// programmed latency, plays a DQS preamble plus BL8 read burst out of column storage
// or captures a BL8 write burst into it. Define DDR_RESP_DM_EN to add the dm_n mask.
module ddr_dq_responder #(
  parameter int unsigned DQ_WIDTH = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned TS_W     = 16
) (
  input logic               CK_t,
  input logic               reset,
  ddr_dq_responder_if.slave bus
);
  localparam int unsigned PtrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW  = $clog2(QDEPTH + 1);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StPreamble, StBurst, StPostamble} state_e;

  // Command queue and column storage (not reset).
  logic                q_wr_q  [QDEPTH];
  logic [ADDR_W-1:0]   q_col_q [QDEPTH];
  logic [TS_W-1:0]     q_ts_q  [QDEPTH];
  logic [DQ_WIDTH-1:0] mem_q   [Depth];

  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [TS_W-1:0]     now_q, now_d;
  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [1:0]          pre_cnt_q, pre_cnt_d;
  logic                cur_wr_q, cur_wr_d;
  logic [ADDR_W-1:0]   cur_col_q, cur_col_d;
  logic [DQ_WIDTH-1:0] dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                dqs_t_q, dqs_t_d;
  logic                dqs_c_q, dqs_c_d;
  logic                dqs_oe_q, dqs_oe_d;
  logic                wr_beat_q, wr_beat_d;
  logic                overflow_q, overflow_d;
  logic                late_q, late_d;

  logic                full, pop, push, start, wr_en;
  logic                h_v, h_wr;
  logic [ADDR_W-1:0]   h_col;
  logic [TS_W-1:0]     h_e;
  logic [PtrW-1:0]     h_ptr;
  logic [TS_W-1:0]     rl, wl, pre_off, pre_len;
  logic                go_burst, go_pre, go_late;
  logic                rd_beat;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic                unused_sig;

  assign full = (count_q == CntW'(QDEPTH));
  assign pop  = (state_q == StBurst) && (beat_q == 3'd7);
  // A pop frees a slot in the same cycle, so a full queue still accepts then.
  assign push = bus.cas_valid && (!full || pop);

  assign rl      = TS_W'(bus.CL) + TS_W'(bus.AL);
  assign wl      = TS_W'(bus.CWL) + TS_W'(bus.AL);
  assign pre_off = rl - TS_W'(bus.RD_PRE);

  assign wr_addr = {cur_col_q[ADDR_W-1:3], 3'(cur_col_q[2:0] + beat_q)};
`ifdef DDR_RESP_DM_EN
  assign wr_en = (state_q == StBurst) && cur_wr_q && bus.dm_n;
`else
  assign wr_en = (state_q == StBurst) && cur_wr_q;
`endif

  // Head as seen after this cycle's pop; an empty queue exposes the incoming CAS.
  always_comb begin
    h_ptr = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    h_v   = 1'b0;
    h_wr  = bus.cas_is_wr;
    h_col = bus.cas_col;
    h_e   = '0;
    if (count_q > CntW'(pop)) begin
      h_v   = 1'b1;
      h_wr  = q_wr_q[h_ptr];
      h_col = q_col_q[h_ptr];
      h_e   = now_q - q_ts_q[h_ptr];
    end else if (push) begin
      h_v = 1'b1;
    end
  end

  // Decide whether the head starts next cycle, from which stage, and whether it is late.
  always_comb begin
    go_burst = 1'b0;
    go_pre   = 1'b0;
    go_late  = 1'b0;
    pre_len  = '0;
    if (h_v) begin
      if (h_wr) begin
        // Read-to-write turnaround must pass through IDLE.
        if ((state_q == StIdle || cur_wr_q) && (h_e >= wl - TS_W'(1))) begin
          go_burst = 1'b1;
          go_late  = (h_e >= wl);
        end
      end else if ((state_q == StIdle || !cur_wr_q) && (h_e + TS_W'(1) >= pre_off)) begin
        // A seamless read-after-read skips its preamble on purpose; that is not late.
        go_late = (h_e >= pre_off) && !((state_q != StIdle) && (h_e + TS_W'(1) == rl));
        if (h_e + TS_W'(1) < rl) begin
          go_pre  = 1'b1;
          pre_len = rl - h_e - TS_W'(1);
        end else begin
          go_burst = 1'b1;
        end
      end
    end
  end

  // Next-state for queue, FSM and registered bus outputs.
  always_comb begin
    now_d      = now_q + TS_W'(1);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q | (bus.cas_valid && full && !pop);

    state_d   = state_q;
    beat_d    = beat_q;
    pre_cnt_d = pre_cnt_q;
    cur_wr_d  = cur_wr_q;
    cur_col_d = cur_col_q;
    start     = (state_q == StIdle || pop) && (go_burst || go_pre);
    late_d    = late_q | (start && go_late);

    if (start) begin
      cur_wr_d  = h_wr;
      cur_col_d = h_col;
      beat_d    = 3'd0;
      pre_cnt_d = pre_len[1:0];
      state_d   = go_pre ? StPreamble : StBurst;
    end else begin
      case (state_q)
        StIdle: ;
        StPreamble: begin
          if (pre_cnt_q <= 2'd1) begin
            state_d = StBurst;
            beat_d  = 3'd0;
          end else begin
            pre_cnt_d = pre_cnt_q - 2'd1;
          end
        end
        StBurst: begin
          if (beat_q != 3'd7) begin
            beat_d = beat_q + 3'd1;
          end else begin
            state_d = cur_wr_q ? StIdle : StPostamble;
          end
        end
        StPostamble: state_d = StIdle;
        default:     state_d = StIdle;
      endcase
    end

    rd_beat   = (state_d == StBurst) && !cur_wr_d;
    rd_addr   = {cur_col_d[ADDR_W-1:3], 3'(cur_col_d[2:0] + beat_d)};
    dq_out_d  = rd_beat ? mem_q[rd_addr] : '0;
    dq_oe_d   = rd_beat;
    dqs_oe_d  = rd_beat || (state_d == StPreamble) || (state_d == StPostamble);
    dqs_t_d   = rd_beat && !beat_d[0];
    dqs_c_d   = !dqs_t_d;
    wr_beat_d = (state_d == StBurst) && cur_wr_d;
  end

  // Control state and registered outputs, cleared by the asynchronous reset.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      now_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      beat_q     <= 3'd0;
      pre_cnt_q  <= 2'd0;
      cur_wr_q   <= 1'b0;
      cur_col_q  <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqs_t_q    <= 1'b0;
      dqs_c_q    <= 1'b1;
      dqs_oe_q   <= 1'b0;
      wr_beat_q  <= 1'b0;
      overflow_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      now_q      <= now_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      pre_cnt_q  <= pre_cnt_d;
      cur_wr_q   <= cur_wr_d;
      cur_col_q  <= cur_col_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dqs_t_q    <= dqs_t_d;
      dqs_c_q    <= dqs_c_d;
      dqs_oe_q   <= dqs_oe_d;
      wr_beat_q  <= wr_beat_d;
      overflow_q <= overflow_d;
      late_q     <= late_d;
    end
  end

  // Queue entries and column storage hold data only, so they carry no reset.
  always_ff @(posedge CK_t) begin
    if (push) begin
      q_wr_q[wr_ptr_q]  <= bus.cas_is_wr;
      q_col_q[wr_ptr_q] <= bus.cas_col;
      q_ts_q[wr_ptr_q]  <= now_q;
    end
    if (wr_en) begin
      mem_q[wr_addr] <= bus.dq_in;
    end
  end

  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.dqs_t    = dqs_t_q;
  assign bus.dqs_c    = dqs_c_q;
  assign bus.dqs_oe   = dqs_oe_q;
  assign bus.wr_beat  = wr_beat_q;
  assign bus.busy     = (count_q != '0) || (state_q != StIdle);
  assign bus.overflow = overflow_q;
  assign bus.late_err = late_q;

  // Write preamble length only moves the write start, which WL already encodes.
  assign unused_sig = ^{bus.WR_PRE, pre_len[TS_W-1:2]};
endmodule

// File: tb/tb_ddr_dq_responder.sv
// Self-checking bench for ddr_dq_responder: each scenario task drives CAS commands and
// compares the bus cycle by cycle against timing and data derived from the latency rules.
module tb_ddr_dq_responder;
  logic CK_t = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] mdl_mem [1024];
  bit         mdl_known [1024];
  int         last_col = 16;

  ddr_dq_responder_if #(.DQ_WIDTH(8), .ADDR_W(10)) bus ();

  ddr_dq_responder #(.DQ_WIDTH(8), .ADDR_W(10), .QDEPTH(4), .TS_W(16)) dut (
    .CK_t  (CK_t),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CK_t = ~CK_t;

  // Beat i of a BL8 burst wraps inside the aligned block of eight columns.
  function automatic int beat_addr(input int col, input int i);
    return (col & ~7) | ((col + i) % 8);
  endfunction

  task automatic apply_reset();
    bus.cas_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge CK_t);
    reset = 1'b0;
    @(negedge CK_t);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge CK_t);
    n_checks++; if (bus.dq_out !== 8'h00) begin n_fail++; $display("FAIL rst_dq_out got=%h exp=00", bus.dq_out); end
    n_checks++; if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dq_oe got=%b exp=0", bus.dq_oe); end
    n_checks++; if (bus.dqs_t !== 1'b0) begin n_fail++; $display("FAIL rst_dqs_t got=%b exp=0", bus.dqs_t); end
    n_checks++; if (bus.dqs_c !== 1'b1) begin n_fail++; $display("FAIL rst_dqs_c got=%b exp=1", bus.dqs_c); end
    n_checks++; if (bus.dqs_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dqs_oe got=%b exp=0", bus.dqs_oe); end
    n_checks++; if (bus.wr_beat !== 1'b0) begin n_fail++; $display("FAIL rst_wr_beat got=%b exp=0", bus.wr_beat); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
    n_checks++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL rst_late_err got=%b exp=0", bus.late_err); end
    reset = 1'b0;
    @(negedge CK_t);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
  endtask

  // One write burst; seq_base >= 0 gives data seq_base+i, otherwise random data.
  // mask bit i set means dm_n low on beat i (only meaningful with the mask feature).
  task automatic test_write(input int col, input int cwl, input int al, input int seq_base,
                            input logic [7:0] mask);
    int wl, b;
    logic [7:0] data [8];
    logic exp_wb, exp_busy;
    wl = cwl + al;
    for (int i = 0; i < 8; i++) data[i] = (seq_base >= 0) ? 8'(seq_base + i) : 8'($urandom);
    bus.CWL = 5'(cwl); bus.AL = 5'(al);
    bus.cas_valid = 1'b1; bus.cas_is_wr = 1'b1; bus.cas_col = 10'(col);
    for (int d = 0; d <= wl + 9; d++) begin
      if (d > 0) @(negedge CK_t);
      if (d == 1) bus.cas_valid = 1'b0;
      b = d - wl;
      exp_wb = (b >= 0 && b < 8);
      bus.dq_in = exp_wb ? data[b] : 8'($urandom);
`ifdef DDR_RESP_DM_EN
      bus.dm_n = !(exp_wb && mask[b]);
`endif
      exp_busy = (d >= 1 && d <= wl + 7);
      n_checks++; if (bus.wr_beat !== exp_wb) begin n_fail++; $display("FAIL wr_beat col=%0h d=%0d got=%b exp=%b", col, d, bus.wr_beat, exp_wb); end
      n_checks++; if (bus.dqs_oe !== 1'b0) begin n_fail++; $display("FAIL wr_dqs_oe d=%0d got=%b exp=0", d, bus.dqs_oe); end
      n_checks++; if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_dq_oe d=%0d got=%b exp=0", d, bus.dq_oe); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL wr_busy d=%0d got=%b exp=%b", d, bus.busy, exp_busy); end
    end
`ifdef DDR_RESP_DM_EN
    bus.dm_n = 1'b1;
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef DDR_RESP_DM_EN
      if (mask[i]) continue;
`endif
      mdl_mem[beat_addr(col, i)]   = data[i];
      mdl_known[beat_addr(col, i)] = 1'b1;
    end
    last_col = col;
    n_checks++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL wr_late_err got=%b exp=0", bus.late_err); end
  endtask

  task automatic test_read(input int col, input int cl, input int al, input int pre);
    int rl, b, a;
    logic exp_oe, exp_soe, exp_t, exp_busy;
    rl = cl + al;
    bus.CL = 5'(cl); bus.AL = 5'(al); bus.RD_PRE = 2'(pre);
    bus.cas_valid = 1'b1; bus.cas_is_wr = 1'b0; bus.cas_col = 10'(col);
    for (int d = 0; d <= rl + 10; d++) begin
      if (d > 0) @(negedge CK_t);
      if (d == 1) bus.cas_valid = 1'b0;
      b = d - rl;
      exp_oe   = (b >= 0 && b < 8);
      exp_soe  = (d >= rl - pre && d <= rl + 8);
      exp_t    = exp_oe && (b % 2 == 0);
      exp_busy = (d >= 1 && d <= rl + 8);
      n_checks++; if (bus.dq_oe !== exp_oe) begin n_fail++; $display("FAIL rd_dq_oe col=%0h d=%0d got=%b exp=%b", col, d, bus.dq_oe, exp_oe); end
      n_checks++; if (bus.dqs_oe !== exp_soe) begin n_fail++; $display("FAIL rd_dqs_oe col=%0h d=%0d got=%b exp=%b", col, d, bus.dqs_oe, exp_soe); end
      n_checks++; if (bus.dqs_t !== exp_t) begin n_fail++; $display("FAIL rd_dqs_t d=%0d got=%b exp=%b", d, bus.dqs_t, exp_t); end
      n_checks++; if (bus.dqs_c !== !exp_t) begin n_fail++; $display("FAIL rd_dqs_c d=%0d got=%b exp=%b", d, bus.dqs_c, !exp_t); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL rd_busy d=%0d got=%b exp=%b", d, bus.busy, exp_busy); end
      if (exp_oe) begin
        a = beat_addr(col, b);
        if (mdl_known[a]) begin
          n_checks++; if (bus.dq_out !== mdl_mem[a]) begin n_fail++; $display("FAIL rd_data col=%0h beat=%0d got=%h exp=%h", col, b, bus.dq_out, mdl_mem[a]); end
        end
      end
    end
    n_checks++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL rd_late_err got=%b exp=0", bus.late_err); end
  endtask

  // Two reads eight cycles apart must merge into one 16-beat seamless burst.
  task automatic test_back_to_back(input int cola, input int colb, input int pre);
    int rl, b, a;
    logic exp_oe, exp_soe, exp_t;
    rl = 11;
    bus.CL = 5'd11; bus.AL = 5'd0; bus.RD_PRE = 2'(pre);
    bus.cas_valid = 1'b1; bus.cas_is_wr = 1'b0; bus.cas_col = 10'(cola);
    for (int d = 0; d <= rl + 20; d++) begin
      if (d > 0) @(negedge CK_t);
      if (d == 1) bus.cas_valid = 1'b0;
      if (d == 8) begin bus.cas_valid = 1'b1; bus.cas_col = 10'(colb); end
      if (d == 9) bus.cas_valid = 1'b0;
      b = d - rl;
      exp_oe  = (b >= 0 && b < 16);
      exp_soe = (d >= rl - pre && d <= rl + 16);
      exp_t   = exp_oe && (b % 2 == 0);
      n_checks++; if (bus.dq_oe !== exp_oe) begin n_fail++; $display("FAIL b2b_dq_oe d=%0d got=%b exp=%b", d, bus.dq_oe, exp_oe); end
      n_checks++; if (bus.dqs_oe !== exp_soe) begin n_fail++; $display("FAIL b2b_dqs_oe d=%0d got=%b exp=%b", d, bus.dqs_oe, exp_soe); end
      n_checks++; if (bus.dqs_t !== exp_t) begin n_fail++; $display("FAIL b2b_dqs_t d=%0d got=%b exp=%b", d, bus.dqs_t, exp_t); end
      n_checks++; if (bus.late_err !== 1'b0) begin n_fail++; $display("FAIL b2b_late_err d=%0d got=%b exp=0", d, bus.late_err); end
      if (exp_oe) begin
        a = beat_addr((b < 8) ? cola : colb, b % 8);
        if (mdl_known[a]) begin
          n_checks++; if (bus.dq_out !== mdl_mem[a]) begin n_fail++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", b, bus.dq_out, mdl_mem[a]); end
        end
      end
    end
  endtask

  // Five reads on consecutive cycles against a four-deep queue.
  task automatic test_overflow();
    int rl, b, a;
    int cols [5];
    logic exp_oe, exp_ovf, exp_late;
    rl = 11;
    for (int i = 0; i < 5; i++) cols[i] = 16 | int'($urandom % 8);
    bus.CL = 5'd11; bus.AL = 5'd0; bus.RD_PRE = 2'd1;
    bus.cas_is_wr = 1'b0;
    for (int d = 0; d <= rl + 42; d++) begin
      if (d > 0) @(negedge CK_t);
      bus.cas_valid = (d < 5);
      bus.cas_col   = 10'(cols[(d < 5) ? d : 4]);
      b = d - rl;
      exp_oe   = (b >= 0 && b < 32);
      exp_ovf  = (d >= 5);
      exp_late = (d >= rl + 8);
      n_checks++; if (bus.dq_oe !== exp_oe) begin n_fail++; $display("FAIL ovf_dq_oe d=%0d got=%b exp=%b", d, bus.dq_oe, exp_oe); end
      n_checks++; if (bus.overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag d=%0d got=%b exp=%b", d, bus.overflow, exp_ovf); end
      n_checks++; if (bus.late_err !== exp_late) begin n_fail++; $display("FAIL ovf_late_err d=%0d got=%b exp=%b", d, bus.late_err, exp_late); end
      if (exp_oe) begin
        a = beat_addr(cols[b / 8], b % 8);
        if (mdl_known[a]) begin
          n_checks++; if (bus.dq_out !== mdl_mem[a]) begin n_fail++; $display("FAIL ovf_data beat=%0d got=%h exp=%h", b, bus.dq_out, mdl_mem[a]); end
        end
      end
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end got=%b exp=0", bus.busy); end
  endtask

  // Reset lands in the middle of beat 3 of a read burst.
  task automatic test_reset_mid(input int col);
    int rl;
    rl = 11;
    bus.CL = 5'd11; bus.AL = 5'd0; bus.RD_PRE = 2'd1;
    bus.cas_valid = 1'b1; bus.cas_is_wr = 1'b0; bus.cas_col = 10'(col);
    for (int d = 1; d <= rl + 3; d++) begin
      @(negedge CK_t);
      bus.cas_valid = 1'b0;
    end
    n_checks++; if (bus.dq_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_dq_oe got=%b exp=1", bus.dq_oe); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL mid_dq_oe got=%b exp=0", bus.dq_oe); end
    n_checks++; if (bus.dqs_oe !== 1'b0) begin n_fail++; $display("FAIL mid_dqs_oe got=%b exp=0", bus.dqs_oe); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.dqs_c !== 1'b1) begin n_fail++; $display("FAIL mid_dqs_c got=%b exp=1", bus.dqs_c); end
    @(negedge CK_t);
    reset = 1'b0;
    @(negedge CK_t);
    test_read(col, 11, 0, 1);
  endtask

  task automatic test_random_mix(input int n);
    int col, pre, cl;
    for (int k = 0; k < n; k++) begin
      if ($urandom % 2 == 0) begin
        col = int'($urandom % 1024);
        test_write(col, int'($urandom_range(1, 20)), int'($urandom_range(0, 5)), -1, 8'h00);
      end else begin
        col = (last_col & ~7) | int'($urandom % 8);
        pre = int'($urandom_range(1, 2));
        cl  = int'($urandom_range(2, 20));
        test_read(col, cl, int'($urandom_range(0, 5)), pre);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cas_valid = 1'b0; bus.cas_is_wr = 1'b0; bus.cas_col = '0;
    bus.CL = 5'd11; bus.CWL = 5'd9; bus.AL = 5'd0;
    bus.RD_PRE = 2'd1; bus.WR_PRE = 2'd1; bus.dq_in = '0;
`ifdef DDR_RESP_DM_EN
    bus.dm_n = 1'b1;
`endif
    test_reset();
    test_write(16, 9, 0, 8'hA0, 8'h00);
    test_read(16, 11, 0, 1);
    test_read(21, 11, 0, 1);
    test_read(19, 11, 0, 2);
    test_write(24, 5, 2, -1, 8'h00);
    test_back_to_back(16 | int'($urandom % 8), 24 | int'($urandom % 8), 1);
    test_back_to_back(16 | int'($urandom % 8), 24 | int'($urandom % 8), 2);
    apply_reset();
    test_overflow();
    apply_reset();
    test_reset_mid(16 | int'($urandom % 8));
`ifdef DDR_RESP_DM_EN
    test_write(32, 6, 0, -1, 8'h00);
    test_write(32, 6, 0, -1, 8'b0010_0100);
    test_read(32, 8, 0, 1);
`endif
    test_random_mix(16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_dq_responder.md
Name: ddr_dq_responder

Overview:
- DRAM-side counterpart of the controller's read/write timing FSM; sits in the memory model behind the DDR bus.
- Accepts CAS commands (RD/WR) from the command decoder and queues them with their issue time.
- At the programmed latency, drives DQS preamble and a BL8 read burst from internal column storage, or captures a BL8 write burst into it.
- Used by the bench as the responder that checks controller CAS-to-data timing.

Parameters:
- DQ_WIDTH, 8, data bus width per beat.
- ADDR_W, 10, column address width; storage depth 2**ADDR_W words.
- QDEPTH, 4, pending CAS command queue depth (power of 2).
- TS_W, 16, issue-timestamp/cycle-counter width.

Ports:
- CK_t  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cas_valid  in  1  CAS command present this cycle.
- cas_is_wr  in  1  1 = WR, 0 = RD.
- cas_col  in  ADDR_W  starting column.
- CL, CWL, AL  in  5 each  latencies in CK cycles; static while busy.
- RD_PRE, WR_PRE  in  2 each  preamble length in cycles (1 or 2).
- dq_in  in  DQ_WIDTH  write data from controller.
- dq_out  out  DQ_WIDTH  read data beat.
- dq_oe  out  1  dq_out valid/driven.
- dqs_t, dqs_c  out  1 each  strobe pair.
- dqs_oe  out  1  strobe driven by responder (read preamble/burst/postamble only).
- wr_beat  out  1  a write beat is being captured this cycle.
- busy  out  1  queue non-empty or FSM not IDLE.
- overflow  out  1  sticky; CAS arrived with queue full.
- late_err  out  1  sticky; queue head matured while bus still occupied.

Behaviour:
- Reset (async, any time, including mid-burst): dq_out=0, dq_oe=0, dqs_t=0, dqs_c=1, dqs_oe=0, wr_beat=0, busy=0, overflow=0, late_err=0. The queue is emptied, FSM goes to IDLE, and the cycle counter goes to 0. Storage is not reset.
- Free-running counter `now` (TS_W bits, wraps). On cas_valid with queue not full, push {is_wr, col, ts=now}. Accepted CAS at cycle T0.
- Latencies:
  - Read: RL = CL+AL. Preamble starts at T0+RL-RD_PRE. Beats occupy T0+RL .. T0+RL+7.
  - Write: WL = CWL+AL. Beats captured at T0+WL .. T0+WL+7.
  - WR_PRE only sets write start = T0+WL; no strobe is driven for writes.
  - RL-RD_PRE >= 1 and WL >= 1 are required; other values are undefined.
- Maturity: `now-ts` uses modular TS_W subtraction. Only the queue head is examined; service is strictly in order.
- FSM states: IDLE, PREAMBLE, BURST, POSTAMBLE.
- IDLE:
  - Read head at preamble start → PREAMBLE, with dqs_oe=1, dqs_t=0, dqs_c=1.
  - Write head at data start → BURST.
- PREAMBLE: hold for RD_PRE cycles, then → BURST.
- BURST: 8 beats, beat index i = 0..7. Address = {col[ADDR_W-1:3], (col[2:0]+i) mod 8} (sequential wrap within aligned block of 8).
  - Read: dq_out = mem[addr], dq_oe=1; dqs_t toggles each beat starting at 1, dqs_c = ~dqs_t.
  - Write: mem[addr] <= dq_in, wr_beat=1.
  - Head is popped on beat 7.
- At beat 7, examine the new head (a CAS pushed the same cycle counts):
  - Data start == now+1 and same direction → BURST (seamless, no preamble/postamble).
  - Read with preamble start == now+1 → PREAMBLE.
  - Otherwise → POSTAMBLE for one cycle (read only: dqs_oe=1, dqs_t=0; a write skips POSTAMBLE), then IDLE.
- Read→write or write→read turnaround always passes through POSTAMBLE/IDLE.
- Late head: a head whose start time has already passed when it is examined sets late_err. That command is then served immediately from its current stage.
- Simultaneous push at pop with queue full: the push is accepted (slot freed same cycle).
- Push with queue full and no pop: command dropped, overflow=1.
- busy = queue non-empty OR state != IDLE.

Optional Feature:
- Macro DDR_RESP_DM_EN.
- When defined: adds input dm_n [1] (active-low data mask). Write beats with dm_n=0 do not update storage; wr_beat still asserts.
- When undefined: no dm_n port; all write beats are stored.

Test Plan:
- Reset, CWL=9, AL=0, WR CAS col 0x10 at T0, dq_in 0xA0..0xA7 at T0+9..T0+16 → wr_beat high exactly those 8 cycles; mem[0x10..0x17]=0xA0..0xA7.
- Then CL=11, RD_PRE=1, RD col 0x10 at T1 → dqs_oe rises T1+10 (dqs_t=0), dq_oe T1+11..T1+18 with 0xA0..0xA7; dqs_t toggles 1,0,1…; POSTAMBLE at T1+19; IDLE and dqs_oe=0 at T1+20.
- RD col 0x15 after same write → beat order 0x15,0x16,0x17,0x10..0x14 → data 0xA5,A6,A7,A0..A4.
- Two RDs at T and T+8, CL=11 → 16 contiguous dq_oe cycles T+11..T+26; no preamble between bursts; late_err=0.
- Five RDs on consecutive cycles, QDEPTH=4 → overflow=1 on the 5th; only 4 bursts issued; late_err=1 on 2nd head (overlap).
- Assert reset at beat 3 of a read burst → same cycle dq_oe=0, dqs_oe=0, busy=0. After release, a new RD works normally.
- With DDR_RESP_DM_EN: write col 0x20, dm_n=0 on beats 2 and 5 → those locations retain old data; others updated.
